ccx_chunk_responder: RTL and testbench
======================================

Name: ccx_chunk_responder

Overview:
- Synthesizable responder for the chunk-serial custom-instruction (CCX) interface of the FazyRV exotiny core.
- The core streams two 32-bit operands CHUNKSIZE bits per cycle, LSB chunk first, and pulses a request. This block returns the result in the same chunk format and pulses a response on the last result chunk.
- Intended for mapping into the eFPGA beside the core. Replaces the trivial AND model used by the simulation wrapper, and supports serial arithmetic carried across chunks.

Parameters:
- CHUNKSIZE, 4, operand/result bits per cycle; legal values 1, 2, 4, 8; NCH = 32/CHUNKSIZE.
- RES_DLY, 1, cycles from operand chunk k to result chunk k; must be >= 1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_in  input  1  asynchronous active-low reset.
- ccx_req_i  input  1  one-cycle pulse coincident with operand chunk 0.
- ccx_sel_i  input  1  unit select; request is accepted only when 1 at the req cycle.
- ccx_op_i  input  2  operation, sampled at the req cycle: 00 AND, 01 XOR, 10 ADD, 11 SUB (a-b).
- ccx_rs_a_i  input  CHUNKSIZE  operand A chunk.
- ccx_rs_b_i  input  CHUNKSIZE  operand B chunk.
- ccx_res_o  output  CHUNKSIZE  result chunk.
- ccx_resp_o  output  1  one-cycle pulse coincident with the last result chunk.
- busy_o  output  1  high while in the operand phase.
- err_o  output  1  sticky flag: a request arrived while busy.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counter 0; carry 0; pipeline cleared. Reset is asynchronous and aborts any operation in flight; no resp is issued for an aborted operation.
- FSM IDLE: on req_i & sel_i at cycle t:
  - process chunk 0 in the same cycle;
  - latch op; cnt <= 1; go to RUN; busy_o = 1 from t+1.
  - For ADD, chunk 0 uses carry-in 0. For SUB, chunk 0 uses carry-in 1 with B inverted.
- FSM RUN: process chunk cnt each cycle; cnt increments. After processing chunk NCH-1 (cycle t+NCH-1), return to IDLE.
  - busy_o is low from t+NCH, so a new request is accepted at t+NCH (back-to-back).
- Carry: {c, r} = a + b' + c_in with width CHUNKSIZE+1; c is registered for the next chunk. The final carry out is discarded (32-bit wrap-around). AND/XOR ignore carry.
- Result path:
  - The chunk result enters a RES_DLY-deep shift register with a valid tag. ccx_res_o = pipeline output when valid, else 0.
  - Chunk k of the request at t appears at t+k+RES_DLY.
  - ccx_resp_o = 1 exactly at t+NCH-1+RES_DLY; 0 otherwise.
- Valid/last tags travel with the data. Result windows of back-to-back operations are contiguous and do not overlap.
- req while busy (RUN): ignored (does not restart or corrupt the current op); err_o <= 1 and stays set until reset.
- req with sel_i=0: ignored; no output activity.
- Operand inputs outside the operand phase are don't-care and must not affect outputs.
- CHUNKSIZE=8 (NCH=4) and CHUNKSIZE=1 (NCH=32): the counter is sized $clog2(NCH); the last-chunk compare uses NCH-1 and must not rely on counter wrap.

Test Plan:
- AND, CHUNKSIZE=4, RES_DLY=1: A=0xF0F01234, B=0xFFFF00FF, req at t -> res chunks 4,3,0,0,0,F,0,F at t+1..t+8; resp only at t+8; res_o 0 at t+9.
- ADD carry chain: A=0xFFFFFFFF, B=0x00000001 -> all eight result chunks 0 (carry propagates, final carry dropped); then A=0x0000000F, B=1 -> result 0x00000010.
- SUB: A=5, B=7 -> result 0xFFFFFFFE (chunks E,F,F,F,F,F,F,F); A=B=0x12345678 -> 0.
- Back-to-back and collision:
  - XOR at t, ADD at t+8 -> two contiguous 8-chunk result windows; resp at t+8 and t+16.
  - Extra req at t+3 -> ignored, result unchanged, err_o=1 from t+4.
- Reset mid-operation: assert rst_in at t+4 -> outputs 0 immediately, no resp. After release, a new AND op completes correctly and err_o=0.
- Parameter sweep: CHUNKSIZE in {1,2,8}, RES_DLY in {1,3}, random ops/operands vs. a 32-bit golden model; resp at t+NCH-1+RES_DLY.

Source files
------------

// File: rtl/ccx_chunk_responder.sv
// Chunk-serial CCX responder: AND/XOR/ADD/SUB on two 32-bit operands streamed LSB chunk first,
// with the carry held between chunks and results returned through a RES_DLY-deep tagged pipeline.
module ccx_chunk_responder #(
    parameter int unsigned CHUNKSIZE = 4,
    parameter int unsigned RES_DLY   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 ccx_req_i,
    input  logic                 ccx_sel_i,
    input  logic [1:0]           ccx_op_i,
    input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
    input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
    output logic [CHUNKSIZE-1:0] ccx_res_o,
    output logic                 ccx_resp_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned NCH  = 32 / CHUNKSIZE;
    localparam int unsigned CntW = $clog2(NCH);
    localparam logic [CntW-1:0] LastCnt = CntW'(NCH - 1);

    typedef enum logic [1:0] {OpAnd = 2'b00, OpXor = 2'b01, OpAdd = 2'b10, OpSub = 2'b11} op_e;
    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    op_e                 op_q, op_d;
    logic                carry_q, carry_d;
    logic                err_q, err_d;

    logic [RES_DLY-1:0][CHUNKSIZE-1:0] pipe_data_q, pipe_data_d;
    logic [RES_DLY-1:0]                pipe_vld_q, pipe_vld_d;
    logic [RES_DLY-1:0]                pipe_last_q, pipe_last_d;

    logic                start;
    logic                active;
    logic                last;
    op_e                 cur_op;
    logic                cin;
    logic [CHUNKSIZE-1:0] b_eff;
    logic [CHUNKSIZE:0]   sum;
    logic [CHUNKSIZE-1:0] chunk_res;

    // Chunk datapath: chunk 0 is processed in the request cycle using the live op.
    always_comb begin
        start  = (state_q == StIdle) && ccx_req_i && ccx_sel_i;
        active = start || (state_q == StRun);
        last   = (state_q == StRun) && (cnt_q == LastCnt);
        cur_op = start ? op_e'(ccx_op_i) : op_q;
        cin    = start ? (cur_op == OpSub) : carry_q;
        b_eff  = (cur_op == OpSub) ? ~ccx_rs_b_i : ccx_rs_b_i;
        sum    = {1'b0, ccx_rs_a_i} + {1'b0, b_eff} + {{CHUNKSIZE{1'b0}}, cin};
        case (cur_op)
            OpAnd:   chunk_res = ccx_rs_a_i & ccx_rs_b_i;
            OpXor:   chunk_res = ccx_rs_a_i ^ ccx_rs_b_i;
            default: chunk_res = sum[CHUNKSIZE-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        carry_d = carry_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = CntW'(1);
                    op_d    = cur_op;
                    carry_d = sum[CHUNKSIZE];
                end
            end
            default: begin
                cnt_d   = cnt_q + CntW'(1);
                carry_d = sum[CHUNKSIZE];
                if (ccx_req_i && ccx_sel_i) begin
                    err_d = 1'b1;
                end
                // Final carry out is dropped: 32-bit wrap-around.
                if (last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        pipe_data_d    = pipe_data_q;
        pipe_vld_d     = pipe_vld_q;
        pipe_last_d    = pipe_last_q;
        pipe_data_d[0] = active ? chunk_res : '0;
        pipe_vld_d[0]  = active;
        pipe_last_d[0] = last;
        for (int unsigned i = 1; i < RES_DLY; i++) begin
            pipe_data_d[i] = pipe_data_q[i-1];
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= OpAnd;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            pipe_data_q <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            pipe_data_q <= pipe_data_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    assign ccx_res_o  = pipe_vld_q[RES_DLY-1] ? pipe_data_q[RES_DLY-1] : '0;
    assign ccx_resp_o = pipe_vld_q[RES_DLY-1] & pipe_last_q[RES_DLY-1];
    assign busy_o     = (state_q == StRun);
    assign err_o      = err_q;

endmodule

// File: tb/tb_ccx_chunk_responder.sv
// Bench for ccx_chunk_responder: directed scenarios on a 4-bit/1-cycle instance plus a randomized
// sweep of 1/2/8-bit instances against a 32-bit golden model.
module tb_ccx_chunk_responder;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // Main instance: CHUNKSIZE=4, RES_DLY=1
    logic       req, sel;
    logic [1:0] op;
    logic [3:0] a, b, res;
    logic       resp, busy, err;

    // Sweep instances: index 0 -> (1,3), 1 -> (2,1), 2 -> (8,3)
    logic       s_req, s_sel;
    logic [1:0] s_op;
    logic [7:0] s_a [3];
    logic [7:0] s_b [3];
    logic [7:0] s_res [3];
    logic [2:0] s_resp, s_busy, s_err;
    logic [0:0] res_cs1;
    logic [1:0] res_cs2;
    logic [7:0] res_cs8;

    ccx_chunk_responder #(.CHUNKSIZE(4), .RES_DLY(1)) u_dut (
        .clk_i(clk), .rst_in(rst_n), .ccx_req_i(req), .ccx_sel_i(sel), .ccx_op_i(op),
        .ccx_rs_a_i(a), .ccx_rs_b_i(b), .ccx_res_o(res), .ccx_resp_o(resp),
        .busy_o(busy), .err_o(err)
    );

    ccx_chunk_responder #(.CHUNKSIZE(1), .RES_DLY(3)) u_cs1 (
        .clk_i(clk), .rst_in(rst_n), .ccx_req_i(s_req), .ccx_sel_i(s_sel), .ccx_op_i(s_op),
        .ccx_rs_a_i(s_a[0][0:0]), .ccx_rs_b_i(s_b[0][0:0]), .ccx_res_o(res_cs1),
        .ccx_resp_o(s_resp[0]), .busy_o(s_busy[0]), .err_o(s_err[0])
    );

    ccx_chunk_responder #(.CHUNKSIZE(2), .RES_DLY(1)) u_cs2 (
        .clk_i(clk), .rst_in(rst_n), .ccx_req_i(s_req), .ccx_sel_i(s_sel), .ccx_op_i(s_op),
        .ccx_rs_a_i(s_a[1][1:0]), .ccx_rs_b_i(s_b[1][1:0]), .ccx_res_o(res_cs2),
        .ccx_resp_o(s_resp[1]), .busy_o(s_busy[1]), .err_o(s_err[1])
    );

    ccx_chunk_responder #(.CHUNKSIZE(8), .RES_DLY(3)) u_cs8 (
        .clk_i(clk), .rst_in(rst_n), .ccx_req_i(s_req), .ccx_sel_i(s_sel), .ccx_op_i(s_op),
        .ccx_rs_a_i(s_a[2]), .ccx_rs_b_i(s_b[2]), .ccx_res_o(res_cs8),
        .ccx_resp_o(s_resp[2]), .busy_o(s_busy[2]), .err_o(s_err[2])
    );

    assign s_res[0] = {7'b0, res_cs1};
    assign s_res[1] = {6'b0, res_cs2};
    assign s_res[2] = res_cs8;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-cycle plan for the main instance and the outputs captured in each cycle.
    logic       p_req [64];
    logic       p_sel [64];
    logic [1:0] p_op  [64];
    logic [3:0] p_a   [64];
    logic [3:0] p_b   [64];
    logic [3:0] g_res [64];
    logic       g_resp[64];
    logic       g_busy[64];
    logic       g_err [64];

    function automatic logic [31:0] golden(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        case (o)
            OP_AND:  return x & y;
            OP_XOR:  return x ^ y;
            OP_ADD:  return x + y;
            default: return x - y;
        endcase
    endfunction

    function automatic logic [31:0] assemble(input int base);
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = g_res[base + k];
        return r;
    endfunction

    function automatic int cs_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic int rd_of(input int d);
        return (d == 1) ? 1 : 3;
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < 64; i++) begin
            p_req[i] = 1'b0;
            p_sel[i] = 1'($urandom);
            p_op[i]  = 2'($urandom);
            p_a[i]   = 4'($urandom);
            p_b[i]   = 4'($urandom);
        end
    endtask

    task automatic plan_op(input int t, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y);
        p_req[t] = 1'b1;
        p_sel[t] = 1'b1;
        p_op[t]  = o;
        for (int k = 0; k < 8; k++) begin
            p_a[t+k] = x[4*k +: 4];
            p_b[t+k] = y[4*k +: 4];
        end
    endtask

    // Cycle c: outputs sampled at the negedge opening cycle c, then inputs for cycle c driven.
    task automatic run_plan(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            g_res[c]  = res;
            g_resp[c] = resp;
            g_busy[c] = busy;
            g_err[c]  = err;
            req = p_req[c];
            sel = p_sel[c];
            op  = p_op[c];
            a   = p_a[c];
            b   = p_b[c];
        end
    endtask

    task automatic test_reset();
        req = 1'b0; sel = 1'b1; op = OP_ADD; a = 4'hF; b = 4'hF;
        s_req = 1'b0; s_sel = 1'b1; s_op = OP_ADD;
        for (int d = 0; d < 3; d++) begin
            s_a[d] = 8'hFF;
            s_b[d] = 8'hFF;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({res, resp, busy, err} !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_main got=%b exp=0000000", {res, resp, busy, err});
        end
        n_checks++;
        if ({s_resp, s_busy, s_err} !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_sweep got=%b exp=0", {s_resp, s_busy, s_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unselected();
        clear_plan();
        p_req[2] = 1'b1;
        p_sel[2] = 1'b0;
        run_plan(14);
        for (int c = 0; c < 14; c++) begin
            n_checks++;
            if ({g_res[c], g_resp[c], g_busy[c]} !== 6'd0) begin
                n_errors++;
                $display("FAIL unsel c=%0d got=%b exp=0", c, {g_res[c], g_resp[c], g_busy[c]});
            end
        end
    endtask

    task automatic test_and();
        logic [3:0] exp_chunks [8] = '{4'h4, 4'h3, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF};
        clear_plan();
        plan_op(2, OP_AND, 32'hF0F01234, 32'hFFFF00FF);
        run_plan(14);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (g_res[3+k] !== exp_chunks[k]) begin
                n_errors++;
                $display("FAIL and_chunk k=%0d got=%h exp=%h", k, g_res[3+k], exp_chunks[k]);
            end
        end
        for (int c = 0; c < 14; c++) begin
            n_checks++;
            if (g_resp[c] !== (c == 10)) begin
                n_errors++;
                $display("FAIL and_resp c=%0d got=%b exp=%b", c, g_resp[c], (c == 10));
            end
        end
        n_checks++;
        if (g_res[11] !== 4'h0 || g_res[2] !== 4'h0) begin
            n_errors++;
            $display("FAIL and_idle_res got=%h,%h exp=0,0", g_res[2], g_res[11]);
        end
    endtask

    task automatic test_add_carry();
        clear_plan();
        plan_op(2, OP_ADD, 32'hFFFFFFFF, 32'h1);
        plan_op(12, OP_ADD, 32'h0000000F, 32'h1);
        run_plan(24);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (g_res[3+k] !== 4'h0) begin
                n_errors++;
                $display("FAIL add_wrap k=%0d got=%h exp=0", k, g_res[3+k]);
            end
        end
        n_checks++;
        if (assemble(13) !== 32'h10) begin
            n_errors++;
            $display("FAIL add_carry got=%h exp=00000010", assemble(13));
        end
        for (int c = 0; c < 24; c++) begin
            n_checks++;
            if (g_resp[c] !== (c == 10 || c == 20)) begin
                n_errors++;
                $display("FAIL add_resp c=%0d got=%b", c, g_resp[c]);
            end
        end
    endtask

    task automatic test_sub();
        clear_plan();
        plan_op(2, OP_SUB, 32'd5, 32'd7);
        plan_op(10, OP_SUB, 32'h12345678, 32'h12345678);
        run_plan(22);
        n_checks++;
        if (assemble(3) !== 32'hFFFFFFFE) begin
            n_errors++;
            $display("FAIL sub_neg got=%h exp=fffffffe", assemble(3));
        end
        n_checks++;
        if (assemble(11) !== 32'h0) begin
            n_errors++;
            $display("FAIL sub_zero got=%h exp=00000000", assemble(11));
        end
        for (int c = 0; c < 22; c++) begin
            n_checks++;
            if (g_resp[c] !== (c == 10 || c == 18)) begin
                n_errors++;
                $display("FAIL sub_resp c=%0d got=%b", c, g_resp[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2;
        logic        exp_busy;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        clear_plan();
        plan_op(2, OP_XOR, x1, y1);
        plan_op(10, OP_ADD, x2, y2);
        run_plan(22);
        n_checks++;
        if (assemble(3) !== golden(OP_XOR, x1, y1)) begin
            n_errors++;
            $display("FAIL b2b_xor got=%h exp=%h", assemble(3), golden(OP_XOR, x1, y1));
        end
        n_checks++;
        if (assemble(11) !== golden(OP_ADD, x2, y2)) begin
            n_errors++;
            $display("FAIL b2b_add got=%h exp=%h", assemble(11), golden(OP_ADD, x2, y2));
        end
        for (int c = 0; c < 22; c++) begin
            exp_busy = (c >= 3 && c <= 9) || (c >= 11 && c <= 17);
            n_checks++;
            if (g_resp[c] !== (c == 10 || c == 18) || g_busy[c] !== exp_busy) begin
                n_errors++;
                $display("FAIL b2b_ctl c=%0d resp=%b busy=%b exp_busy=%b", c, g_resp[c],
                         g_busy[c], exp_busy);
            end
            if (c <= 2 || c >= 19) begin
                n_checks++;
                if (g_res[c] !== 4'h0) begin
                    n_errors++;
                    $display("FAIL b2b_idle_res c=%0d got=%h exp=0", c, g_res[c]);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        clear_plan();
        plan_op(2, OP_AND, x, y);
        p_req[5] = 1'b1;
        p_sel[5] = 1'b1;
        p_op[5]  = OP_SUB;
        run_plan(14);
        n_checks++;
        if (assemble(3) !== (x & y)) begin
            n_errors++;
            $display("FAIL coll_result got=%h exp=%h", assemble(3), x & y);
        end
        for (int c = 0; c < 14; c++) begin
            n_checks++;
            if (g_err[c] !== (c >= 6) || g_resp[c] !== (c == 10)) begin
                n_errors++;
                $display("FAIL coll_ctl c=%0d err=%b resp=%b exp_err=%b", c, g_err[c],
                         g_resp[c], (c >= 6));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] x, y;
        clear_plan();
        plan_op(2, OP_ADD, $urandom, $urandom);
        run_plan(6);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_pre busy=%b err=%b exp=1,1", busy, err);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({res, resp, busy, err} !== 7'd0) begin
            n_errors++;
            $display("FAIL midrst_async got=%b exp=0000000", {res, resp, busy, err});
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (resp !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_hold_resp got=%b exp=0", resp);
            end
        end
        rst_n = 1'b1;
        x = $urandom; y = $urandom;
        clear_plan();
        plan_op(2, OP_AND, x, y);
        run_plan(14);
        n_checks++;
        if (assemble(3) !== (x & y)) begin
            n_errors++;
            $display("FAIL midrst_after got=%h exp=%h", assemble(3), x & y);
        end
        for (int c = 0; c < 14; c++) begin
            n_checks++;
            if (g_resp[c] !== (c == 10) || g_err[c] !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_ctl c=%0d resp=%b err=%b", c, g_resp[c], g_err[c]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [1:0]  o;
        logic [31:0] x, y, r;
        logic [31:0] m, exp_res;
        int          cs, rd, nch, k;
        for (int it = 0; it < 12; it++) begin
            o = 2'($urandom);
            x = (it % 4 == 0) ? 32'hFFFFFFFF : $urandom;
            y = (it % 4 == 0) ? 32'h1 : $urandom;
            r = golden(o, x, y);
            for (int c = 0; c <= 40; c++) begin
                @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    cs  = cs_of(d);
                    rd  = rd_of(d);
                    nch = 32 / cs;
                    m   = (32'd1 << cs) - 32'd1;
                    k   = c - rd;
                    exp_res = (k >= 0 && k < nch) ? ((r >> (k * cs)) & m) : 32'd0;
                    if (c >= 1) begin
                        n_checks++;
                        if ({24'd0, s_res[d]} !== exp_res) begin
                            n_errors++;
                            $display("FAIL sweep_res d=%0d it=%0d c=%0d got=%h exp=%h", d, it,
                                     c, s_res[d], exp_res);
                        end
                        n_checks++;
                        if (s_resp[d] !== (c == nch - 1 + rd) ||
                            s_busy[d] !== (c <= nch - 1)) begin
                            n_errors++;
                            $display("FAIL sweep_ctl d=%0d it=%0d c=%0d resp=%b busy=%b", d,
                                     it, c, s_resp[d], s_busy[d]);
                        end
                    end
                    s_a[d] = (c < nch) ? 8'((x >> (c * cs)) & m) : 8'($urandom);
                    s_b[d] = (c < nch) ? 8'((y >> (c * cs)) & m) : 8'($urandom);
                end
                s_req = (c == 0);
                s_sel = (c == 0) ? 1'b1 : 1'($urandom);
                s_op  = (c == 0) ? o : 2'($urandom);
            end
        end
        n_checks++;
        if (s_err !== 3'b000) begin
            n_errors++;
            $display("FAIL sweep_err got=%b exp=000", s_err);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_unselected();
        test_and();
        test_add_carry();
        test_sub();
        test_back_to_back();
        test_collision();
        test_reset_mid_op();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
